// File: rtl/operand_acc_pkg.sv
// operand_acc_pkg: shared state encoding, default sizes and counter-width helper for operand_accumulator
package operand_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_N_OPS = 4;

    // Counter must hold values 0..n_ops inclusive.
    function automatic int cnt_w_f(input int n_ops);
        return $clog2(n_ops + 1);
    endfunction

endpackage

// File: rtl/acc_add_core.sv
// acc_add_core: combinational WIDTH-bit ripple-carry adder built from full-adder cells
//   a, b  : addends
//   cin   : carry into bit 0
//   sum   : low WIDTH bits of a + b + cin
//   cout  : carry out of the top bit
module acc_add_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] c;

    assign c[0] = cin;
    assign cout = c[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

endmodule

// File: rtl/operand_accumulator.sv
// operand_accumulator: sums N_OPS handshaked operands through a ripple adder, counting carry-outs
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : begin an accumulation (honoured only in IDLE)
//   in_valid/in_ready    : operand handshake, in_data is the operand
//   out_valid/out_ready  : result handshake
//   out_sum              : low WIDTH bits of the total
//   out_carries, out_ovf : carry count (upper part of the total), nonzero-carry flag
// Build option OPERAND_ACC_SATURATE_EN: out_sum reads all-ones when any carry occurred.
module operand_accumulator
    import operand_acc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_OPS = DEF_N_OPS,
    parameter int CNT_W = cnt_w_f(N_OPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_carries,
    output logic             out_ovf
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, out_sum_q, out_sum_d, add_sum, result;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d, carry_cnt_q, carry_cnt_d, out_carries_q, out_carries_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
    logic             add_cout, accept;

    acc_add_core #(.WIDTH(WIDTH)) u_add (
        .a    (acc_q),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // in_ready_q is high exactly while in ACCUM, so it doubles as the state qualifier.
    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        op_cnt_d    = op_cnt_q;
        carry_cnt_d = carry_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d       = '0;
                    op_cnt_d    = '0;
                    carry_cnt_d = '0;
                    state_d     = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d       = add_sum;
                    carry_cnt_d = carry_cnt_q + CNT_W'(add_cout);
                    op_cnt_d    = op_cnt_q + 1'b1;
                    state_d     = (op_cnt_q == CNT_W'(N_OPS - 1)) ? DONE : ACCUM;
                end
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
`ifdef OPERAND_ACC_SATURATE_EN
        result = (carry_cnt_d != '0) ? '1 : acc_d;
`else
        result = acc_d;
`endif
        // Result registers load on entry to DONE and hold afterwards, keeping outputs registered.
        in_ready_d    = (state_d == ACCUM);
        out_valid_d   = (state_d == DONE);
        out_sum_d     = out_valid_d ? result : out_sum_q;
        out_carries_d = out_valid_d ? carry_cnt_d : out_carries_q;
        out_ovf_d     = out_valid_d ? (carry_cnt_d != '0) : out_ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            op_cnt_q      <= '0;
            carry_cnt_q   <= '0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_sum_q     <= '0;
            out_carries_q <= '0;
            out_ovf_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            op_cnt_q      <= op_cnt_d;
            carry_cnt_q   <= carry_cnt_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_sum_q     <= out_sum_d;
            out_carries_q <= out_carries_d;
            out_ovf_q     <= out_ovf_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_sum     = out_sum_q;
    assign out_carries = out_carries_q;
    assign out_ovf     = out_ovf_q;

endmodule
